note_scheduler: RTL



---
 rtl/note_scheduler_if.sv | 29 ++
 rtl/note_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler_if.sv
// note_scheduler_if: event bus from the key-capture stage into the note
// scheduler queue. The capture side is the master; the scheduler is the slave.
interface note_scheduler_if #(
    parameter int OCTAVE_W = 3,
    parameter int NOTE_W   = 3,
    parameter int LENGTH_W = 3
);
    logic                in_valid;
    logic                in_ready;
    logic [OCTAVE_W-1:0] in_octave;
    logic [NOTE_W-1:0]   in_note;
    logic [LENGTH_W-1:0] in_length;

    modport master (
        output in_valid,
        output in_octave,
        output in_note,
        output in_length,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_octave,
        input  in_note,
        input  in_length,
        output in_ready
    );
endinterface

// File: rtl/note_scheduler.sv
// note_scheduler: queues (octave, note, length) events from the key-capture
// stage and plays them one at a time towards the tone driver. Each note lasts
// (1 << length) ticks of TICK_CYCLES clocks; the final GAP_CYCLES of every
// note are silent so that repeated notes stay audibly separate.
//
// Optional build macro NOTE_SCHED_TEMPO_EN adds a 2-bit tempo input that
// shortens the tick to TICK_CYCLES >> tempo. Without it the tick is fixed.
//
// The pause input (en) is sampled at each clock edge. Its effect is seen in
// the following cycle, because every tone output is a register.
module note_scheduler #(
    parameter int OCTAVE_W    = 3,
    parameter int NOTE_W      = 3,
    parameter int LENGTH_W    = 3,
    parameter int DEPTH       = 8,
    parameter int TICK_CYCLES = 50000,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
`ifdef NOTE_SCHED_TEMPO_EN
    input  logic [1:0]              tempo,
`endif
    note_scheduler_if.slave         evt,
    output logic [OCTAVE_W-1:0]     out_octave,
    output logic [NOTE_W-1:0]       out_note,
    output logic                    out_active,
    output logic                    note_done,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LVL_W   = AW + 1;
    localparam int ENTRY_W = OCTAVE_W + NOTE_W + LENGTH_W;
    // The longest note is 64 ticks, so the down-counter holds 64*TICK_CYCLES-1.
    localparam int CNT_W   = $clog2(64 * TICK_CYCLES);

    localparam logic [NOTE_W-1:0]   REST_NOTE = NOTE_W'(7);
    localparam logic [LENGTH_W-1:0] MAX_LEN   = LENGTH_W'(6);
    localparam logic [CNT_W-1:0]    GAP_C     = CNT_W'(GAP_CYCLES);
    localparam logic [LVL_W-1:0]    FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic [LENGTH_W-1:0] push_len;

    logic [OCTAVE_W-1:0] head_octave;
    logic [NOTE_W-1:0]   head_note;
    logic [LENGTH_W-1:0] head_len;

    state_t state;
    state_t state_next;

    assign empty        = (level == '0);
    assign full         = (level == FULL_LVL);
    assign evt.in_ready = !full;

    // Lengths above 64 ticks are not representable, so they saturate on entry.
    assign push_len = (evt.in_length > MAX_LEN) ? MAX_LEN : evt.in_length;

    // A flush wins over a same-cycle push, so that event is discarded.
    assign push = evt.in_valid && !full && !flush;
    assign pop  = (state == S_LOAD) && !empty && !flush;

    assign {head_octave, head_note, head_len} = mem[rd_ptr];

    // Queue storage: written at the tail on each accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {evt.in_octave, evt.in_note, push_len};
        end
    end

    // Queue pointers and occupancy; the pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Note duration for the head entry
    // ------------------------------------------------------------------
    logic [CNT_W:0]   unit_cycles;
    logic [CNT_W:0]   note_cycles;
    logic [CNT_W-1:0] load_count;

    // Total note length minus one. A tempo large enough to shift the
    // tick to zero is held at one clock so the counter cannot underflow.
    always_comb begin
`ifdef NOTE_SCHED_TEMPO_EN
        unit_cycles = (CNT_W+1)'(TICK_CYCLES) >> tempo;
`else
        unit_cycles = (CNT_W+1)'(TICK_CYCLES);
`endif
        if (unit_cycles == '0) begin
            unit_cycles = (CNT_W+1)'(1);
        end
        note_cycles = unit_cycles << head_len;
        load_count  = CNT_W'(note_cycles - (CNT_W+1)'(1));
    end

    // ------------------------------------------------------------------
    // Playback FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    cycles_left;
    logic [CNT_W-1:0]    cnt_next;
    logic                live;
    logic [OCTAVE_W-1:0] cur_octave;
    logic [OCTAVE_W-1:0] cur_octave_next;
    logic [NOTE_W-1:0]   cur_note;
    logic [NOTE_W-1:0]   cur_note_next;
    logic                sounding;
    logic                playing;
    logic [OCTAVE_W-1:0] out_octave_next;
    logic [NOTE_W-1:0]   out_note_next;
    logic                out_active_next;
    logic                note_done_next;

    // Next state, countdown and the values the tone outputs take next cycle.
    // 'live' marks a cycle that was entered with en high; only live cycles
    // advance the countdown, which keeps the tone length exact across pauses.
    always_comb begin
        state_next      = state;
        cnt_next        = cycles_left;
        cur_octave_next = cur_octave;
        cur_note_next   = cur_note;

        case (state)
            S_IDLE: begin
                if (en && !empty) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next      = S_RUN;
                cnt_next        = load_count;
                cur_octave_next = head_octave;
                cur_note_next   = head_note;
            end
            S_RUN: begin
                if (live) begin
                    if (cycles_left == '0) begin
                        state_next = (en && !empty) ? S_LOAD : S_IDLE;
                    end else begin
                        cnt_next = cycles_left - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (flush) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end

        sounding        = (state_next == S_RUN) && en;
        playing         = sounding && (cnt_next >= GAP_C);
        out_note_next   = playing ? cur_note_next : REST_NOTE;
        out_active_next = playing && (cur_note_next != REST_NOTE);
        out_octave_next = flush ? '0 : (playing ? cur_octave_next : out_octave);
        note_done_next  = sounding && (cnt_next == '0);
    end

    // State register plus the registered tone outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cycles_left <= '0;
            live        <= 1'b0;
            cur_octave  <= '0;
            cur_note    <= REST_NOTE;
            out_octave  <= '0;
            out_note    <= REST_NOTE;
            out_active  <= 1'b0;
            note_done   <= 1'b0;
        end else begin
            state       <= state_next;
            cycles_left <= cnt_next;
            live        <= en && !flush;
            cur_octave  <= cur_octave_next;
            cur_note    <= cur_note_next;
            out_octave  <= out_octave_next;
            out_note    <= out_note_next;
            out_active  <= out_active_next;
            note_done   <= note_done_next;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
